// File: rtl/module_alu_seq_pkg.sv
// Shared types and constants for the sequential ALU.
// Optional multiplier: define ALU_MUL_EN to add the MUL state.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_AND = 4'd0,
        OP_OR  = 4'd1,
        OP_ADD = 4'd2,
        OP_INC = 4'd3,
        OP_DEC = 4'd4,
        OP_NOT = 4'd5,
        OP_SUB = 4'd6,
        OP_XOR = 4'd7,
        OP_SLL = 4'd8,
        OP_SRL = 4'd9,
        OP_MUL = 4'd10
    } alu_op_t;

    // The MUL state only exists when the multiplier is built in.
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
`ifdef ALU_MUL_EN
        MUL,
`endif
        DONE
    } alu_state_t;

endpackage

// File: rtl/module_alu_seq_if.sv
// Request/response bundle of the sequential ALU.
// Handshake: a request is taken on a rising clock edge where valid_i=1 and
// ready_o=1; valid_o is a one-cycle pulse marking a new registered result,
// and the result/flag outputs hold until the next result is written.
interface module_alu_seq_if
    import alu_pkg::*;
#(
    parameter int N = 8
);
    logic                valid_i;
    logic                ready_o;
    logic [N-1:0]        A_i;
    logic [N-1:0]        B_i;
    logic [ALU_OP_W-1:0] alucont_i;
    logic                flagin_i;
    logic                valid_o;
    logic [N-1:0]        aluresult_o;
    logic                flagout_o;
    logic                flagz_o;
    logic                flagv_o;

    modport master (
        output valid_i, A_i, B_i, alucont_i, flagin_i,
        input  ready_o, valid_o, aluresult_o, flagout_o, flagz_o, flagv_o
    );

    modport slave (
        input  valid_i, A_i, B_i, alucont_i, flagin_i,
        output ready_o, valid_o, aluresult_o, flagout_o, flagz_o, flagv_o
    );
endinterface

// File: rtl/module_alu_seq_core.sv
// Combinational datapath for the single-cycle opcodes 0-7.
// flagin selects carry-in for ADD and the operand (0=A, 1=B) for INC/DEC/NOT.
module module_alu_core
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]        a_i,
    input  logic [N-1:0]        b_i,
    input  logic [ALU_OP_W-1:0] op_i,
    input  logic                cin_i,
    output logic [N-1:0]        result_o,
    output logic                cout_o,
    output logic                ovf_o
);
    logic [N-1:0] sel;
    logic [N:0]   sum;

    // Arithmetic and logic result for the selected opcode.
    always_comb begin
        result_o = '0;
        cout_o   = 1'b0;
        ovf_o    = 1'b0;
        sum      = '0;
        sel      = cin_i ? b_i : a_i;
        case (op_i)
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_ADD: begin
                sum      = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};
                result_o = sum[N-1:0];
                cout_o   = sum[N];
                ovf_o    = (a_i[N-1] == b_i[N-1]) && (sum[N-1] != a_i[N-1]);
            end
            OP_INC: begin
                sum      = {1'b0, sel} + (N+1)'(1);
                result_o = sum[N-1:0];
                cout_o   = sum[N];
            end
            OP_DEC: begin
                result_o = sel - N'(1);
                cout_o   = (sel == '0);
            end
            OP_NOT: result_o = ~sel;
            OP_SUB: begin
                // Carry out of A + ~B + 1 is 1 when no borrow occurred.
                sum      = {1'b0, a_i} + {1'b0, ~b_i} + (N+1)'(1);
                result_o = sum[N-1:0];
                cout_o   = sum[N];
                ovf_o    = (a_i[N-1] != b_i[N-1]) && (sum[N-1] != a_i[N-1]);
            end
            OP_XOR: result_o = a_i ^ b_i;
            default: ;
        endcase
    end
endmodule

// File: rtl/module_alu_seq.sv
// Sequential ALU: single-cycle ops via module_alu_core, bit-serial shifts,
// and (with ALU_MUL_EN defined) an N-cycle unsigned shift-add multiplier.
// Without ALU_MUL_EN, opcode 10 is handled as an illegal opcode.
module module_alu_seq
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    module_alu_seq_if.slave bus,
    output alu_state_t      dbg_state_o
);
    localparam int CW = $clog2(N + 1);

    alu_state_t    state_q;
    logic          ready_q;
    logic          valid_q;
    logic [N-1:0]  result_q;
    logic          flagout_q;
    logic          flagz_q;
    logic          flagv_q;
    logic [N-1:0]  work_q;
    logic          srl_q;
    logic [CW-1:0] cnt_q;

    logic [CW-1:0] k_d;
    logic [N-1:0]  shift_d;
    logic          shout_d;

    logic [N-1:0]  core_res;
    logic          core_cout;
    logic          core_ovf;

`ifdef ALU_MUL_EN
    logic [2*N-1:0] prod_q;
    logic [2*N-1:0] prod_d;
    logic [N:0]     psum_d;
`endif

    module_alu_core #(.N(N)) u_core (
        .a_i      (bus.A_i),
        .b_i      (bus.B_i),
        .op_i     (bus.alucont_i),
        .cin_i    (bus.flagin_i),
        .result_o (core_res),
        .cout_o   (core_cout),
        .ovf_o    (core_ovf)
    );

    // Shift count clamp, one-bit shift step, and multiply step.
    always_comb begin
        k_d     = (bus.B_i >= N'(N)) ? CW'(N) : bus.B_i[CW-1:0];
        shift_d = srl_q ? {1'b0, work_q[N-1:1]} : {work_q[N-2:0], 1'b0};
        shout_d = srl_q ? work_q[0] : work_q[N-1];
`ifdef ALU_MUL_EN
        // Add the multiplicand into the upper half when the low bit is set, then shift right.
        psum_d  = {1'b0, prod_q[2*N-1:N]} + (prod_q[0] ? {1'b0, work_q} : '0);
        prod_d  = {psum_d, prod_q[N-1:1]};
`endif
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            result_q  <= '0;
            flagout_q <= 1'b0;
            flagz_q   <= 1'b1;
            flagv_q   <= 1'b0;
            work_q    <= '0;
            srl_q     <= 1'b0;
            cnt_q     <= '0;
`ifdef ALU_MUL_EN
            prod_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (bus.valid_i) begin
                        work_q  <= bus.A_i;
                        srl_q   <= (bus.alucont_i == OP_SRL);
                        ready_q <= 1'b0;
                        case (bus.alucont_i)
                            OP_AND, OP_OR, OP_ADD, OP_INC,
                            OP_DEC, OP_NOT, OP_SUB, OP_XOR: begin
                                result_q  <= core_res;
                                flagout_q <= core_cout;
                                flagv_q   <= core_ovf;
                                flagz_q   <= (core_res == '0);
                                valid_q   <= 1'b1;
                                state_q   <= DONE;
                            end
                            OP_SLL, OP_SRL: begin
                                if (k_d == '0) begin
                                    result_q  <= bus.A_i;
                                    flagout_q <= 1'b0;
                                    flagv_q   <= 1'b0;
                                    flagz_q   <= (bus.A_i == '0);
                                    valid_q   <= 1'b1;
                                    state_q   <= DONE;
                                end else begin
                                    cnt_q   <= k_d;
                                    state_q <= SHIFT;
                                end
                            end
`ifdef ALU_MUL_EN
                            OP_MUL: begin
                                prod_q  <= {{N{1'b0}}, bus.B_i};
                                cnt_q   <= CW'(N);
                                state_q <= MUL;
                            end
`endif
                            default: begin
                                result_q  <= '0;
                                flagout_q <= 1'b0;
                                flagv_q   <= 1'b0;
                                flagz_q   <= 1'b1;
                                valid_q   <= 1'b1;
                                state_q   <= DONE;
                            end
                        endcase
                    end
                end
                SHIFT: begin
                    work_q <= shift_d;
                    cnt_q  <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_q  <= shift_d;
                        flagout_q <= shout_d;
                        flagv_q   <= 1'b0;
                        flagz_q   <= (shift_d == '0);
                        valid_q   <= 1'b1;
                        state_q   <= DONE;
                    end
                end
`ifdef ALU_MUL_EN
                MUL: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_q  <= prod_d[N-1:0];
                        flagout_q <= |prod_d[2*N-1:N];
                        flagv_q   <= 1'b0;
                        flagz_q   <= (prod_d[N-1:0] == '0);
                        valid_q   <= 1'b1;
                        state_q   <= DONE;
                    end
                end
`endif
                DONE: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready_o     = ready_q;
    assign bus.valid_o     = valid_q;
    assign bus.aluresult_o = result_q;
    assign bus.flagout_o   = flagout_q;
    assign bus.flagz_o     = flagz_q;
    assign bus.flagv_o     = flagv_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_module_alu_seq.sv
// Bench for module_alu_seq (N=8); expectations for ALU_MUL_EN follow the define.
module tb_module_alu_seq;
    import alu_pkg::*;

    localparam int N = 8;
    localparam int W = 19;   // {latency[7:0], result[7:0], flagout, flagz, flagv}

    logic       clk;
    logic       rst;
    alu_state_t dbg_state;
    int         checks;
    int         errors;
    logic [W-1:0] exp_q[$];

    module_alu_seq_if #(.N(N)) bus ();

    module_alu_seq #(.N(N)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: expected latency and outputs from the arithmetic definition.
    function automatic logic [W-1:0] model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] op, input logic cin);
        int unsigned x;
        int unsigned k;
        int          s;
        int          lat;
        logic [7:0]  r;
        logic [7:0]  sel;
        logic [7:0]  nb;
        logic        fo;
        logic        fv;
        r   = '0;
        fo  = 1'b0;
        fv  = 1'b0;
        lat = 1;
        x   = 0;
        s   = 0;
        sel = cin ? b : a;
        nb  = ~b;
        k   = (int'(b) > N) ? N : int'(b);
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: begin
                x  = a + b + cin;
                r  = x[7:0];
                fo = x[8];
                s  = int'($signed(a)) + int'($signed(b)) + int'(cin);
                fv = (s > 127) || (s < -128);
            end
            4'd3: begin
                x  = sel + 1;
                r  = x[7:0];
                fo = x[8];
            end
            4'd4: begin
                r  = sel - 8'd1;
                fo = (sel == 8'd0);
            end
            4'd5: r = ~sel;
            4'd6: begin
                x  = a + nb + 1;
                r  = x[7:0];
                fo = x[8];
                s  = int'($signed(a)) - int'($signed(b));
                fv = (s > 127) || (s < -128);
            end
            4'd7: r = a ^ b;
            4'd8: begin
                lat = 1 + int'(k);
                x   = int'(a) << k;
                r   = x[7:0];
                fo  = (k > 0) ? a[8-k] : 1'b0;
            end
            4'd9: begin
                lat = 1 + int'(k);
                r   = a >> k;
                fo  = (k > 0) ? a[k-1] : 1'b0;
            end
`ifdef ALU_MUL_EN
            4'd10: begin
                lat = 1 + N;
                x   = a * b;
                r   = x[7:0];
                fo  = (x[15:8] != 0);
            end
`endif
            default: ;
        endcase
        return {8'(lat), r, fo, (r == 8'd0), fv};
    endfunction

    // Driver: issue one request and wait for its valid_o pulse.
    // lat = cycles after acceptance until valid_o (0 if valid_o never pulsed),
    // nbusy = cycles with ready_o=0 up to valid_o, rdy_after = ready_o one cycle later.
    task automatic send_req(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                            input logic cin, output int lat, output int nbusy,
                            output logic rdy_after, output logic [7:0] r,
                            output logic fo, output logic fz, output logic fv);
        int guard;
        lat = 0; nbusy = 0; rdy_after = 1'b0; r = '0; fo = 1'b0; fz = 1'b0; fv = 1'b0;
        @(negedge clk);
        guard = 0;
        while (bus.ready_o !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        bus.valid_i   = 1'b1;
        bus.A_i       = a;
        bus.B_i       = b;
        bus.alucont_i = op;
        bus.flagin_i  = cin;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            bus.valid_i = 1'b0;
            if (bus.ready_o === 1'b0) nbusy++;
            if (bus.valid_o === 1'b1) begin
                lat = i;
                r   = bus.aluresult_o;
                fo  = bus.flagout_o;
                fz  = bus.flagz_o;
                fv  = bus.flagv_o;
                break;
            end
        end
        @(negedge clk);
        rdy_after = bus.ready_o;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.valid_i = 1'b0; bus.A_i = '0; bus.B_i = '0; bus.alucont_i = '0; bus.flagin_i = 1'b0;
        #2;
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.ready_o); end
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.valid_o); end
        checks++; if (bus.aluresult_o !== 8'h00) begin errors++; $display("FAIL reset_result got=%h exp=00", bus.aluresult_o); end
        checks++; if ({bus.flagout_o, bus.flagz_o, bus.flagv_o} !== 3'b010) begin errors++;
            $display("FAIL reset_flags got=%b exp=010", {bus.flagout_o, bus.flagz_o, bus.flagv_o}); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add_sub();
        int lat, nb; logic ra; logic [7:0] r; logic fo, fz, fv;
        send_req(8'hF0, 8'h20, OP_ADD, 1'b1, lat, nb, ra, r, fo, fz, fv);
        checks++; if (lat != 1) begin errors++; $display("FAIL add_latency got=%0d exp=1", lat); end
        checks++; if ({r, fo, fv, fz} !== {8'h11, 3'b100}) begin errors++;
            $display("FAIL add_result got=%h fo=%b fv=%b fz=%b exp=11 fo=1 fv=0 fz=0", r, fo, fv, fz); end
        send_req(8'h80, 8'h01, OP_SUB, 1'b1, lat, nb, ra, r, fo, fz, fv);
        checks++; if (lat != 1) begin errors++; $display("FAIL sub_latency got=%0d exp=1", lat); end
        checks++; if ({r, fo, fv, fz} !== {8'h7F, 3'b110}) begin errors++;
            $display("FAIL sub_result got=%h fo=%b fv=%b fz=%b exp=7f fo=1 fv=1 fz=0", r, fo, fv, fz); end
        send_req(8'h00, 8'h01, OP_DEC, 1'b0, lat, nb, ra, r, fo, fz, fv);
        checks++; if ({r, fo, fv, fz} !== {8'hFF, 3'b100}) begin errors++;
            $display("FAIL dec_borrow got=%h fo=%b fv=%b fz=%b exp=ff fo=1 fv=0 fz=0", r, fo, fv, fz); end
        send_req(8'h12, 8'hFF, OP_INC, 1'b1, lat, nb, ra, r, fo, fz, fv);
        checks++; if ({r, fo, fv, fz} !== {8'h00, 3'b101}) begin errors++;
            $display("FAIL inc_b_carry got=%h fo=%b fv=%b fz=%b exp=00 fo=1 fv=0 fz=1", r, fo, fv, fz); end
    endtask

    task automatic test_shift();
        int lat, nb; logic ra; logic [7:0] r; logic fo, fz, fv;
        send_req(8'h81, 8'd3, OP_SLL, 1'b0, lat, nb, ra, r, fo, fz, fv);
        checks++; if (lat != 4) begin errors++; $display("FAIL sll_latency got=%0d exp=4", lat); end
        checks++; if (nb != 4 || ra !== 1'b1) begin errors++; $display("FAIL sll_busy got=%0d rdy_after=%b exp=4 rdy_after=1", nb, ra); end
        checks++; if ({r, fo} !== {8'h08, 1'b0}) begin errors++; $display("FAIL sll_result got=%h fo=%b exp=08 fo=0", r, fo); end
        send_req(8'hFF, 8'd9, OP_SRL, 1'b0, lat, nb, ra, r, fo, fz, fv);
        checks++; if (lat != 9) begin errors++; $display("FAIL srl_latency got=%0d exp=9", lat); end
        checks++; if ({r, fz, fo} !== {8'h00, 2'b11}) begin errors++; $display("FAIL srl_result got=%h fz=%b fo=%b exp=00 fz=1 fo=1", r, fz, fo); end
        send_req(8'hA5, 8'd0, OP_SRL, 1'b0, lat, nb, ra, r, fo, fz, fv);
        checks++; if (lat != 1 || {r, fo} !== {8'hA5, 1'b0}) begin errors++;
            $display("FAIL shift_zero got lat=%0d r=%h fo=%b exp lat=1 r=a5 fo=0", lat, r, fo); end
    endtask

    task automatic test_mul();
        int lat, nb; logic ra; logic [7:0] r; logic fo, fz, fv;
        send_req(8'h10, 8'h11, OP_MUL, 1'b0, lat, nb, ra, r, fo, fz, fv);
`ifdef ALU_MUL_EN
        checks++; if (lat != 9) begin errors++; $display("FAIL mul_latency got=%0d exp=9", lat); end
        checks++; if ({r, fo, fz, fv} !== {8'h10, 3'b100}) begin errors++;
            $display("FAIL mul_result got=%h fo=%b fz=%b fv=%b exp=10 fo=1 fz=0 fv=0", r, fo, fz, fv); end
`else
        checks++; if (lat != 1) begin errors++; $display("FAIL mul_latency got=%0d exp=1", lat); end
        checks++; if ({r, fo, fz, fv} !== {8'h00, 3'b010}) begin errors++;
            $display("FAIL mul_result got=%h fo=%b fz=%b fv=%b exp=00 fo=0 fz=1 fv=0", r, fo, fz, fv); end
`endif
    endtask

    task automatic test_illegal();
        int lat, nb; logic ra; logic [7:0] r; logic fo, fz, fv;
        send_req(8'hFF, 8'hFF, 4'd13, 1'b1, lat, nb, ra, r, fo, fz, fv);
        checks++; if (lat != 1 || {r, fo, fz, fv} !== {8'h00, 3'b010}) begin errors++;
            $display("FAIL illegal got lat=%0d r=%h fo=%b fz=%b fv=%b exp lat=1 r=00 010", lat, r, fo, fz, fv); end
    endtask

    task automatic test_abort_reset();
        int lat, nb; logic ra; logic [7:0] r; logic fo, fz, fv;
        bit seen;
        send_req(8'h7F, 8'h01, OP_ADD, 1'b0, lat, nb, ra, r, fo, fz, fv);
        checks++; if ({r, fv} !== {8'h80, 1'b1}) begin errors++; $display("FAIL abort_pre got=%h fv=%b exp=80 fv=1", r, fv); end
        @(negedge clk);
        bus.valid_i = 1'b1; bus.A_i = 8'h3C; bus.B_i = 8'd5; bus.alucont_i = OP_SLL; bus.flagin_i = 1'b0;
        @(negedge clk);
        bus.valid_i = 1'b0;
        @(negedge clk);
        checks++; if (dbg_state !== SHIFT) begin errors++; $display("FAIL abort_in_shift got=%0d exp=%0d", dbg_state, SHIFT); end
        rst = 1'b1;
        #1;
        checks++; if ({bus.ready_o, bus.valid_o} !== 2'b10) begin errors++;
            $display("FAIL abort_hs got ready=%b valid=%b exp ready=1 valid=0", bus.ready_o, bus.valid_o); end
        checks++; if ({bus.aluresult_o, bus.flagout_o, bus.flagz_o, bus.flagv_o} !== {8'h00, 3'b010}) begin errors++;
            $display("FAIL abort_outputs got=%h %b%b%b exp=00 010", bus.aluresult_o, bus.flagout_o, bus.flagz_o, bus.flagv_o); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.valid_i = 1'b1; bus.A_i = 8'h01; bus.B_i = 8'h01; bus.alucont_i = OP_ADD; bus.flagin_i = 1'b0;
        @(negedge clk);
        bus.valid_i = 1'b0;
        checks++; if (bus.valid_o !== 1'b1 || bus.aluresult_o !== 8'h02) begin errors++;
            $display("FAIL post_reset_add got valid=%b r=%h exp valid=1 r=02", bus.valid_o, bus.aluresult_o); end
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.valid_o !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL abort_no_valid got=1 exp=0"); end
    endtask

    task automatic test_hold_busy();
        @(negedge clk);
        bus.valid_i = 1'b1; bus.A_i = 8'h81; bus.B_i = 8'd3; bus.alucont_i = OP_SLL; bus.flagin_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL hold_ready c%0d got=%b exp=0", i, bus.ready_o); end
            checks++; if (bus.valid_o !== (i == 4)) begin errors++; $display("FAIL hold_valid c%0d got=%b exp=%b", i, bus.valid_o, (i == 4)); end
            if (i == 4) begin
                checks++; if ({bus.aluresult_o, bus.flagout_o} !== {8'h08, 1'b0}) begin errors++;
                    $display("FAIL hold_result got=%h fo=%b exp=08 fo=0", bus.aluresult_o, bus.flagout_o); end
            end
            bus.A_i = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL hold_ready_after got=%b exp=1", bus.ready_o); end
        bus.A_i = 8'h0F; bus.B_i = 8'h01; bus.alucont_i = OP_ADD;
        @(negedge clk);
        bus.valid_i = 1'b0;
        checks++; if (bus.valid_o !== 1'b1 || bus.aluresult_o !== 8'h10) begin errors++;
            $display("FAIL hold_next got valid=%b r=%h exp valid=1 r=10", bus.valid_o, bus.aluresult_o); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int pulses;
        logic [W-1:0] e;
        logic [3:0] op;
        pulses = 0;
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.valid_o === 1'b1) begin
                pulses++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                checks++; if ({bus.aluresult_o, bus.flagout_o, bus.flagz_o, bus.flagv_o} !== e[10:0]) begin errors++;
                    $display("FAIL b2b_result got=%h %b%b%b exp=%h %b", bus.aluresult_o, bus.flagout_o,
                             bus.flagz_o, bus.flagv_o, e[10:3], e[2:0]); end
            end
            if (bus.ready_o === 1'b1) begin
                case ($urandom_range(0, 3))
                    0: op = OP_ADD;
                    1: op = OP_SUB;
                    2: op = OP_XOR;
                    default: op = OP_OR;
                endcase
                bus.valid_i = 1'b1; bus.alucont_i = op;
                bus.A_i = 8'($urandom_range(0, 255)); bus.B_i = 8'($urandom_range(0, 255));
                bus.flagin_i = 1'($urandom_range(0, 1));
                exp_q.push_back(model(bus.A_i, bus.B_i, bus.alucont_i, bus.flagin_i));
            end
        end
        @(negedge clk);
        bus.valid_i = 1'b0;
        checks++; if (pulses != 10 || exp_q.size() != 0) begin errors++;
            $display("FAIL b2b_rate got pulses=%0d left=%0d exp pulses=10 left=0", pulses, exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_random();
        int lat, nb; logic ra; logic [7:0] r; logic fo, fz, fv;
        logic [7:0] a, b; logic [3:0] op; logic cin;
        logic [W-1:0] e;
        for (int n = 0; n < 30; n++) begin
            op  = 4'($urandom_range(0, 15));
            a   = 8'($urandom_range(0, 255));
            b   = (op == OP_SLL || op == OP_SRL) ? 8'($urandom_range(0, 11)) : 8'($urandom_range(0, 255));
            cin = 1'($urandom_range(0, 1));
            exp_q.push_back(model(a, b, op, cin));
            send_req(a, b, op, cin, lat, nb, ra, r, fo, fz, fv);
            e = exp_q.pop_front();
            checks++; if (lat != int'(e[18:11])) begin errors++;
                $display("FAIL rand_latency op=%0d a=%h b=%h got=%0d exp=%0d", op, a, b, lat, e[18:11]); end
            checks++; if ({r, fo, fz, fv} !== e[10:0]) begin errors++;
                $display("FAIL rand_result op=%0d a=%h b=%h cin=%b got=%h %b%b%b exp=%h %b", op, a, b, cin,
                         r, fo, fz, fv, e[10:3], e[2:0]); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add_sub();
        test_shift();
        test_mul();
        test_illegal();
        test_abort_reset();
        test_hold_busy();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
